np_matrix_mult_seq: RTL
=======================

Name: np_matrix_mult_seq

Overview:
Parametrised sequencer for the FFN matrix-multiply datapath. Sweeps every feature-map address across each of NUM_RAMS weight/feature RAM banks, then repeats the sweep for NUM_PASSES output passes. Generates read strobes plus accumulator clear and enable signals, delayed to match the datapath pipeline. Flags product_rdy per finished pass, and done/busy for the whole job. Sits between the network controller (start/done) and the multiply-accumulate array.

Parameters:
ADDR_WIDTH, 8, feature-map RAM address width
ADDR_MAX, 255, last address read per bank (ADDR_MAX < 2**ADDR_WIDTH)
NUM_RAMS, 4, number of RAM banks; ram_select is one-hot over these
NUM_PASSES, 1, number of full sweeps (output-neuron groups) per start
PASS_WIDTH, 4, width of pass_idx (NUM_PASSES <= 2**PASS_WIDTH)
PIPE_LAT, 3, cycles from rd_en to operand arrival at the accumulator (>= 1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin job; sampled only in IDLE
stall  in  1  hold sequencing (present only with NP_MM_SEQ_STALL_EN)
addr  out  ADDR_WIDTH  RAM read address
ram_select  out  NUM_RAMS  one-hot bank select
pass_idx  out  PASS_WIDTH  current pass number
rd_en  out  1  read strobe; a read is issued this cycle
acc_clear  out  1  clear accumulator (aligned to first operand of a pass)
acc_en  out  1  accumulate operand (aligned to datapath output)
product_rdy  out  1  one-cycle pulse; pass result complete in accumulator
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse on job completion

Behaviour:
- Reset values: state=IDLE; addr=0; ram_select=1 (bank 0); pass_idx=0; rd_en, acc_clear, acc_en, product_rdy, busy, done = 0. The delay line is cleared.
- Reset mid-job aborts immediately. No product_rdy or done is emitted for in-flight reads.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 -> RUN next cycle, with addr=0, ram_select=1, pass_idx=0, busy=1.
  - start=0 -> stay in IDLE.
- RUN:
  - rd_en = 1 (combinational from state, gated by stall).
  - Each issuing cycle advances the counters:
    - addr < ADDR_MAX: addr+1.
    - addr == ADDR_MAX: addr=0 and ram_select rotates left one bit.
    - addr == ADDR_MAX with ram_select on the MSB bank: ram_select=1 and pass_idx+1.
    - That last case on the final pass (pass_idx == NUM_PASSES-1): go to DRAIN. addr, ram_select and pass_idx hold their final values.
- Reads per pass = (ADDR_MAX+1)*NUM_RAMS.
- Delay line: a PIPE_LAT-stage shift register carries {valid, first_of_pass, last_of_pass, last_of_job}, captured from each issued read.
  - At the output stage: acc_en = valid; acc_clear = valid & first_of_pass; product_rdy = valid & last_of_pass.
  - done = valid & last_of_job, coincident with the final product_rdy.
- DRAIN: rd_en=0; the delay line keeps shifting. On done -> IDLE. busy deasserts the cycle after done.
- start while busy (RUN/DRAIN) is ignored. It is not queued.
- start in the same cycle as reset: reset wins.
- start asserted in the cycle done pulses: ignored (state is still DRAIN). A start one cycle later is accepted.
- Counter arithmetic is unsigned and wraps only at the ADDR_MAX/NUM_RAMS/NUM_PASSES boundaries. No overflow is possible given the parameter constraints.
- Degenerate cases:
  - NUM_RAMS=1: ram_select is constant 1.
  - ADDR_MAX=0: one read per bank.
  - A single-read job must give acc_clear, acc_en, product_rdy and done together in one cycle.

Optional Feature:
NP_MM_SEQ_STALL_EN
- Defined: stall port exists.
  - In RUN with stall=1: rd_en=0; addr, ram_select, pass_idx and state hold; an invalid bubble enters the delay line.
  - The delay line never stalls. Data already in flight completes, and product_rdy/done timing shifts by the number of stalled cycles.
  - stall is ignored in IDLE and DRAIN.
- Undefined: no stall port; behaviour is identical to stall tied to 0.

Test Plan:
- Reset check: assert reset 2 cycles -> all outputs 0, ram_select=1, addr=0. Pulse start then reset next cycle -> busy=0, no rd_en or done afterwards.
- Basic job (ADDR_MAX=3, NUM_RAMS=2, NUM_PASSES=2, PIPE_LAT=2): start pulse ->
  - rd_en high exactly 16 consecutive cycles.
  - addr 0,1,2,3 repeating; ram_select 01x4 then 10x4 per pass; pass_idx 0 then 1.
  - acc_clear 2 cycles after read 1 and read 9.
  - product_rdy 2 cycles after reads 8 and 16.
  - done with the second product_rdy; busy falls 1 cycle later.
- start held high through an entire job -> exactly one job. A second job starts the cycle after busy=0 (start then still high).
- Degenerate ADDR_MAX=0, NUM_RAMS=1, NUM_PASSES=1, PIPE_LAT=1 -> one rd_en. The next cycle has acc_clear=acc_en=product_rdy=done=1.
- With NP_MM_SEQ_STALL_EN (basic config), stall=1 for 3 cycles after read 5 -> addr holds at 1 and rd_en=0 for those 3 cycles. The sequence is otherwise unchanged; the product_rdy and done pulses occur 3 cycles later than in the basic-job scenario.
- NUM_RAMS=4, ADDR_MAX=1 -> ram_select 0001,0010,0100,1000 each held 2 reads, then back to 0001 on the next pass.

Source files
------------

// File: rtl/np_matrix_mult_seq.sv
// np_matrix_mult_seq
// Sequencer for the FFN matrix-multiply datapath. For every start it sweeps
// all feature-map addresses 0..ADDR_MAX across each of NUM_RAMS banks, and
// repeats that sweep NUM_PASSES times. Each issued read carries a small tag
// {valid, first_of_pass, last_of_pass, last_of_job} through a PIPE_LAT-deep
// delay line so the accumulator controls line up with operand arrival.
//
// Optional build macro: NP_MM_SEQ_STALL_EN adds the stall input. Without it
// the sequencer behaves as if stall were tied low.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   start        begin a job (sampled only while idle)
//   stall        hold read issue while running (NP_MM_SEQ_STALL_EN only)
//   addr         feature-map RAM read address
//   ram_select   one-hot bank select
//   pass_idx     current pass number
//   rd_en        read issued this cycle
//   acc_clear    clear accumulator, aligned with first operand of a pass
//   acc_en       accumulate the operand arriving this cycle
//   product_rdy  one-cycle pulse, pass result complete
//   busy         job in progress (accepted start until done)
//   done         one-cycle pulse at job completion
module np_matrix_mult_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int ADDR_MAX   = 255,
    parameter int NUM_RAMS   = 4,
    parameter int NUM_PASSES = 1,
    parameter int PASS_WIDTH = 4,
    parameter int PIPE_LAT   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
`ifdef NP_MM_SEQ_STALL_EN
    input  logic                  stall,
`endif
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_RAMS-1:0]   ram_select,
    output logic [PASS_WIDTH-1:0] pass_idx,
    output logic                  rd_en,
    output logic                  acc_clear,
    output logic                  acc_en,
    output logic                  product_rdy,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(ADDR_MAX);
    localparam logic [PASS_WIDTH-1:0] PASS_ZERO  = PASS_WIDTH'(0);
    localparam logic [PASS_WIDTH-1:0] PASS_ONE   = PASS_WIDTH'(1);
    localparam logic [PASS_WIDTH-1:0] PASS_LAST  = PASS_WIDTH'(NUM_PASSES - 1);
    localparam logic [NUM_RAMS-1:0]   BANK_FIRST = NUM_RAMS'(1);

    // Tag bit positions inside each delay-line stage
    localparam int TAG_V  = 3;
    localparam int TAG_F  = 2;
    localparam int TAG_LP = 1;
    localparam int TAG_LJ = 0;

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [NUM_RAMS-1:0]   ram_sel_r;
    logic [PASS_WIDTH-1:0] pass_r;
    logic [3:0]            pipe_r [PIPE_LAT];

    logic                  stall_s;
    logic                  issue_s;
    logic                  addr_wrap_s;
    logic                  bank_wrap_s;
    logic                  job_end_s;
    logic [3:0]            tag_s;
    logic [3:0]            out_tag_s;

`ifdef NP_MM_SEQ_STALL_EN
    assign stall_s = stall;
`else
    assign stall_s = 1'b0;
`endif

    // Next-state logic and the tag describing the read issued this cycle
    always_comb begin
        state_s     = state_r;
        addr_wrap_s = (addr_r == ADDR_LAST);
        // On the MSB bank the next wrap returns to bank 0 of the next pass
        bank_wrap_s = addr_wrap_s && ram_sel_r[NUM_RAMS-1];
        job_end_s   = bank_wrap_s && (pass_r == PASS_LAST);
        issue_s     = (state_r == RUN) && !stall_s;
        // Every tag bit is gated by issue_s so a stall injects an all-zero bubble
        tag_s       = {issue_s,
                       issue_s && (addr_r == ADDR_ZERO) && ram_sel_r[0],
                       issue_s && bank_wrap_s,
                       issue_s && job_end_s};
        out_tag_s   = pipe_r[PIPE_LAT-1];
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && job_end_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                // Leave once the final tag of the job reaches the output stage
                if (out_tag_s[TAG_V] && out_tag_s[TAG_LJ]) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address / bank / pass counters; they hold their final values after the last read
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r    <= ADDR_ZERO;
            ram_sel_r <= BANK_FIRST;
            pass_r    <= PASS_ZERO;
        end else if ((state_r == IDLE) && start) begin
            addr_r    <= ADDR_ZERO;
            ram_sel_r <= BANK_FIRST;
            pass_r    <= PASS_ZERO;
        end else if (issue_s && !job_end_s) begin
            if (!addr_wrap_s) begin
                addr_r <= addr_r + ADDR_ONE;
            end else begin
                addr_r <= ADDR_ZERO;
                if (bank_wrap_s) begin
                    ram_sel_r <= BANK_FIRST;
                    pass_r    <= pass_r + PASS_ONE;
                end else begin
                    ram_sel_r <= ram_sel_r << 1'b1;
                end
            end
        end else begin
            addr_r    <= addr_r;
            ram_sel_r <= ram_sel_r;
            pass_r    <= pass_r;
        end
    end

    // Tag delay line; it never stalls so in-flight reads always complete
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_r[i] <= 4'b0000;
            end
        end else begin
            pipe_r[0] <= tag_s;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign addr        = addr_r;
    assign ram_select  = ram_sel_r;
    assign pass_idx    = pass_r;
    assign rd_en       = issue_s;
    assign acc_en      = out_tag_s[TAG_V];
    assign acc_clear   = out_tag_s[TAG_V] & out_tag_s[TAG_F];
    assign product_rdy = out_tag_s[TAG_V] & out_tag_s[TAG_LP];
    assign done        = out_tag_s[TAG_V] & out_tag_s[TAG_LJ];
    assign busy        = (state_r != IDLE);

endmodule
